// File: rtl/cycle_trace_monitor_if.sv
// Read-side handshake bundle for the cycle trace monitor.
// The monitor drives valid and the head-entry fields; the consumer drives ready.
interface cycle_trace_monitor_if #(
    parameter int STATE_W = 5,
    parameter int INST_W  = 32,
    parameter int CNT_W   = 7
) ();

    logic               rd_valid;
    logic               rd_ready;
    logic [STATE_W-1:0] rd_state;
    logic [INST_W-1:0]  rd_inst;
    logic [CNT_W-1:0]   rd_cycle;

    modport master (
        output rd_valid,
        output rd_state,
        output rd_inst,
        output rd_cycle,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_state,
        input  rd_inst,
        input  rd_cycle,
        output rd_ready
    );

endinterface

// File: rtl/cycle_trace_monitor.sv
// Cycle trace monitor: watches a control unit's state and instruction
// registers, logs every state change into a small FIFO trace buffer,
// counts cycles up to a run limit, flags stalls and latches the first
// exception PC.
// Optional build macro TRACE_TIMESTAMP_EN: when defined, each trace entry
// also stores the cycle count at which it was logged and rd_cycle shows
// it; when undefined the timestamp field is left out and rd_cycle is 0.
module cycle_trace_monitor #(
    parameter int STATE_W     = 5,
    parameter int INST_W      = 32,
    parameter int ADDR_W      = 64,
    parameter int CNT_W       = 7,
    parameter int DEPTH       = 16,
    parameter int STALL_LIMIT = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [STATE_W-1:0]      state_in,
    input  logic [INST_W-1:0]       inst_in,
    input  logic                    causa_in,
    input  logic [ADDR_W-1:0]       epc_in,
    cycle_trace_monitor_if.master   rd,
    output logic [$clog2(DEPTH):0]  level,
    output logic [CNT_W-1:0]        cycle_count,
    output logic                    done,
    output logic                    stall,
    output logic                    overflow,
    output logic                    exc_valid,
    output logic [ADDR_W-1:0]       exc_epc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int RUN_W = $clog2(STALL_LIMIT + 1);

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [LVL_W-1:0] LEVEL_FULL = LVL_W'(DEPTH);
    localparam logic [RUN_W-1:0] RUN_MAX    = RUN_W'(STALL_LIMIT);

`ifdef TRACE_TIMESTAMP_EN
    localparam int ENTRY_W = STATE_W + INST_W + CNT_W;
`else
    localparam int ENTRY_W = STATE_W + INST_W;
`endif

    logic [ENTRY_W-1:0] traceMem_q [DEPTH];

    logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [ENTRY_W-1:0] rdEntry_q, rdEntry_d;
    logic [CNT_W-1:0]   cycleCount_q, cycleCount_d;
    logic               done_q, done_d;
    logic               overflow_q, overflow_d;
    logic               firstCycle_q;
    logic [STATE_W-1:0] prevState_q;
    logic [RUN_W-1:0]   runCount_q, runCount_d;
    logic               excValid_q;
    logic [ADDR_W-1:0]  excEpc_q;

    logic               stateChanged;
    logic               pushReq;
    logic               popOk;
    logic               pushOk;
    logic               isFull;
    logic [ENTRY_W-1:0] wrEntry;

    // Decide this cycle's push/pop, the new head entry and all next-state values.
    always_comb begin
        stateChanged = firstCycle_q || (state_in != prevState_q);
        pushReq      = !done_q && stateChanged;
        popOk        = (level_q != '0) && rd.rd_ready;
        isFull       = (level_q == LEVEL_FULL);
        pushOk       = pushReq && (!isFull || popOk);
`ifdef TRACE_TIMESTAMP_EN
        wrEntry      = {state_in, inst_in, cycleCount_q};
`else
        wrEntry      = {state_in, inst_in};
`endif
        rdPtr_d      = popOk  ? rdPtr_q + 1'b1 : rdPtr_q;
        wrPtr_d      = pushOk ? wrPtr_q + 1'b1 : wrPtr_q;
        level_d      = level_q + LVL_W'(pushOk) - LVL_W'(popOk);
        overflow_d   = overflow_q || (pushReq && isFull && !popOk);

        // When the slot being written is also the new head (buffer was empty
        // or drains to just this entry), memory is not updated yet, so take
        // the write data directly.
        rdEntry_d = rdEntry_q;
        if (level_d != '0) begin
            if (pushOk && (wrPtr_q == rdPtr_d)) begin
                rdEntry_d = wrEntry;
            end else begin
                rdEntry_d = traceMem_q[rdPtr_d];
            end
        end

        cycleCount_d = (cycleCount_q != CNT_MAX) ? cycleCount_q + 1'b1 : cycleCount_q;
        done_d       = done_q || (cycleCount_q == CNT_MAX);

        if (stateChanged) begin
            runCount_d = '0;
        end else if (runCount_q != RUN_MAX) begin
            runCount_d = runCount_q + 1'b1;
        end else begin
            runCount_d = runCount_q;
        end
    end

    // Trace storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (!reset && pushOk) begin
            traceMem_q[wrPtr_q] <= wrEntry;
        end
    end

    // FIFO bookkeeping and the registered head entry presented to the consumer.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            level_q    <= '0;
            rdEntry_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            level_q    <= level_d;
            rdEntry_q  <= rdEntry_d;
            overflow_q <= overflow_d;
        end
    end

    // Saturating cycle counter and sticky run-limit flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycleCount_q <= '0;
            done_q       <= 1'b0;
        end else begin
            cycleCount_q <= cycleCount_d;
            done_q       <= done_d;
        end
    end

    // Change detection history and the unchanged-state run length for stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            firstCycle_q <= 1'b1;
            prevState_q  <= '0;
            runCount_q   <= '0;
        end else begin
            firstCycle_q <= 1'b0;
            prevState_q  <= state_in;
            runCount_q   <= runCount_d;
        end
    end

    // Latch only the first exception PC seen before the run limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            excValid_q <= 1'b0;
            excEpc_q   <= '0;
        end else if (causa_in && !excValid_q && !done_q) begin
            excValid_q <= 1'b1;
            excEpc_q   <= epc_in;
        end
    end

    assign rd.rd_valid = (level_q != '0);
    assign rd.rd_state = rdEntry_q[ENTRY_W-1 -: STATE_W];
    assign rd.rd_inst  = rdEntry_q[ENTRY_W-STATE_W-1 -: INST_W];
`ifdef TRACE_TIMESTAMP_EN
    assign rd.rd_cycle = rdEntry_q[CNT_W-1:0];
`else
    assign rd.rd_cycle = '0;
`endif

    assign level       = level_q;
    assign cycle_count = cycleCount_q;
    assign done        = done_q;
    assign stall       = (runCount_q == RUN_MAX);
    assign overflow    = overflow_q;
    assign exc_valid   = excValid_q;
    assign exc_epc     = excEpc_q;

endmodule

// File: tb/tb_cycle_trace_monitor.sv
// Testbench for cycle_trace_monitor: directed stimulus, a queue-based
// reference model checked every cycle, plus hand-computed pin checks.
module tb_cycle_trace_monitor;

    localparam int STATE_W     = 5;
    localparam int INST_W      = 32;
    localparam int ADDR_W      = 64;
    localparam int CNT_W       = 7;
    localparam int DEPTH       = 16;
    localparam int STALL_LIMIT = 8;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [STATE_W-1:0] st;
        logic [INST_W-1:0]  in;
        logic [CNT_W-1:0]   cy;
    } entry_t;

    logic               clk;
    logic               reset;
    logic [STATE_W-1:0] stateIn;
    logic [INST_W-1:0]  instIn;
    logic               causaIn;
    logic [ADDR_W-1:0]  epcIn;
    logic [$clog2(DEPTH):0] level;
    logic [CNT_W-1:0]   cycleCount;
    logic               done;
    logic               stall;
    logic               overflow;
    logic               excValid;
    logic [ADDR_W-1:0]  excEpc;

    int total = 0;
    int bad   = 0;
    bit checkEn = 0;

    // Reference model state
    entry_t mq[$];
    int     mCnt      = 0;
    bit     mFirst    = 1;
    int     mPrev     = 0;
    int     mRun      = 0;
    bit     mDone     = 0;
    bit     mOvf      = 0;
    bit     mExcV     = 0;
    logic [ADDR_W-1:0] mExcE = '0;
    entry_t mHead     = '0;

    cycle_trace_monitor_if #(.STATE_W(STATE_W), .INST_W(INST_W), .CNT_W(CNT_W)) rdIf ();

    cycle_trace_monitor #(
        .STATE_W(STATE_W), .INST_W(INST_W), .ADDR_W(ADDR_W),
        .CNT_W(CNT_W), .DEPTH(DEPTH), .STALL_LIMIT(STALL_LIMIT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .state_in(stateIn),
        .inst_in(instIn),
        .causa_in(causaIn),
        .epc_in(epcIn),
        .rd(rdIf.master),
        .level(level),
        .cycle_count(cycleCount),
        .done(done),
        .stall(stall),
        .overflow(overflow),
        .exc_valid(excValid),
        .exc_epc(excEpc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of the specified behaviour, applied to the inputs the DUT sees at this edge.
    task automatic modelStep();
        bit     pop;
        bit     push;
        bit     changed;
        entry_t e;
        if (reset) begin
            mq.delete();
            mCnt = 0; mFirst = 1; mPrev = 0; mRun = 0;
            mDone = 0; mOvf = 0; mExcV = 0; mExcE = '0; mHead = '0;
        end else begin
            changed = mFirst || (int'(stateIn) != mPrev);
            push    = !mDone && changed;
            pop     = (mq.size() > 0) && rdIf.rd_ready;
            e.st = stateIn; e.in = instIn; e.cy = CNT_W'(mCnt);
            if (pop) void'(mq.pop_front());
            if (push) begin
                if (mq.size() < DEPTH) mq.push_back(e);
                else mOvf = 1;
            end
            if (mq.size() > 0) mHead = mq[0];
            mRun = changed ? 0 : ((mRun < STALL_LIMIT) ? mRun + 1 : STALL_LIMIT);
            if (causaIn && !mExcV && !mDone) begin
                mExcV = 1;
                mExcE = epcIn;
            end
            if (mCnt == CNT_MAX) mDone = 1;
            else mCnt = mCnt + 1;
            mPrev  = int'(stateIn);
            mFirst = 0;
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [STATE_W-1:0] st,
                                 input logic [INST_W-1:0] inst, input logic causa,
                                 input logic [ADDR_W-1:0] epc, input logic ready);
        reset   = rst;
        stateIn = st;
        instIn  = inst;
        causaIn = causa;
        epcIn   = epc;
        rdIf.rd_ready = ready;
        @(posedge clk);
        modelStep();
        @(negedge clk);
    endtask

    // Compare every DUT output against the model once per cycle.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("rd_valid",    64'(rdIf.rd_valid), 64'(mq.size() != 0));
            checkOutput("level",       64'(level),         64'(mq.size()));
            checkOutput("rd_state",    64'(rdIf.rd_state), 64'(mHead.st));
            checkOutput("rd_inst",     64'(rdIf.rd_inst),  64'(mHead.in));
`ifdef TRACE_TIMESTAMP_EN
            checkOutput("rd_cycle",    64'(rdIf.rd_cycle), 64'(mHead.cy));
`else
            checkOutput("rd_cycle",    64'(rdIf.rd_cycle), 64'(0));
`endif
            checkOutput("cycle_count", 64'(cycleCount),    64'(mCnt));
            checkOutput("done",        64'(done),          64'(mDone));
            checkOutput("stall",       64'(stall),         64'(mRun == STALL_LIMIT));
            checkOutput("overflow",    64'(overflow),      64'(mOvf));
            checkOutput("exc_valid",   64'(excValid),      64'(mExcV));
            checkOutput("exc_epc",     excEpc,             mExcE);
        end
    end

    initial begin
        reset = 1'b1; stateIn = '0; instIn = '0; causaIn = 1'b0; epcIn = '0;
        rdIf.rd_ready = 1'b0;

        applyStimulus(1, 0, 0, 0, 0, 0);
        checkEn = 1;
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("pin_reset_level", 64'(level), 64'd0);
        checkOutput("pin_reset_valid", 64'(rdIf.rd_valid), 64'd0);
        checkOutput("pin_reset_count", 64'(cycleCount), 64'd0);
        checkOutput("pin_reset_exc",   64'(excValid), 64'd0);

        // Constant state 3: one entry, stall after eight unchanged cycles
        for (int i = 0; i < 8; i++) applyStimulus(0, 5'd3, 32'hA, 0, 0, 0);
        checkOutput("pin_stall_pre", 64'(stall), 64'd0);
        for (int i = 0; i < 2; i++) applyStimulus(0, 5'd3, 32'hA, 0, 0, 0);
        checkOutput("pin_stall",     64'(stall), 64'd1);
        checkOutput("pin_one_level", 64'(level), 64'd1);
        checkOutput("pin_one_state", 64'(rdIf.rd_state), 64'd3);
        checkOutput("pin_one_inst",  64'(rdIf.rd_inst), 64'hA);
        checkOutput("pin_one_cycle", 64'(rdIf.rd_cycle), 64'd0);
        checkOutput("pin_one_count", 64'(cycleCount), 64'd10);

        // Toggle 1/2 without reading: fill, then drop the 17th push
        applyStimulus(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++)
            applyStimulus(0, (i % 2 == 0) ? 5'd1 : 5'd2, INST_W'(i + 100), 0, 0, 0);
        checkOutput("pin_full_level", 64'(level), 64'd16);
        checkOutput("pin_full_ovf",   64'(overflow), 64'd0);
        applyStimulus(0, 5'd1, 32'd116, 0, 0, 0);
        checkOutput("pin_ovf",        64'(overflow), 64'd1);
        checkOutput("pin_ovf_level",  64'(level), 64'd16);
        checkOutput("pin_head_state", 64'(rdIf.rd_state), 64'd1);
        checkOutput("pin_head_inst",  64'(rdIf.rd_inst), 64'd100);
        checkOutput("pin_head_cycle", 64'(rdIf.rd_cycle), 64'd0);

        // Full buffer with reads: simultaneous push and pop keep it full
        for (int i = 0; i < 6; i++)
            applyStimulus(0, (i % 2 == 0) ? 5'd2 : 5'd1, INST_W'(i + 200), 0, 0, 1);
        checkOutput("pin_steady_level", 64'(level), 64'd16);
        checkOutput("pin_steady_ovf",   64'(overflow), 64'd1);
        checkOutput("pin_steady_inst",  64'(rdIf.rd_inst), 64'd106);

        // Exceptions: first strobe captured, second ignored
        applyStimulus(0, 5'd7, 32'd0, 1, 64'h100, 1);
        checkOutput("pin_exc_valid", 64'(excValid), 64'd1);
        checkOutput("pin_exc_epc1",  excEpc, 64'h100);
        applyStimulus(0, 5'd7, 32'd0, 0, 64'h0, 1);
        applyStimulus(0, 5'd7, 32'd0, 1, 64'h200, 1);
        checkOutput("pin_exc_epc2",  excEpc, 64'h100);

        // Reset with five entries buffered and a read pending
        applyStimulus(1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) applyStimulus(0, STATE_W'(i), INST_W'(i), 0, 0, 0);
        checkOutput("pin_five_level", 64'(level), 64'd5);
        applyStimulus(1, 5'd9, 32'd9, 0, 0, 1);
        checkOutput("pin_rst_level", 64'(level), 64'd0);
        checkOutput("pin_rst_valid", 64'(rdIf.rd_valid), 64'd0);
        checkOutput("pin_rst_ovf",   64'(overflow), 64'd0);
        checkOutput("pin_rst_done",  64'(done), 64'd0);
        checkOutput("pin_rst_state", 64'(rdIf.rd_state), 64'd0);

        // Run past the cycle limit while draining every cycle
        for (int i = 0; i < 130; i++) begin
            applyStimulus(0, STATE_W'(i % 3), INST_W'(i), 0, 0, 1);
            if (i == 126) begin
                checkOutput("pin_lim_count",  64'(cycleCount), 64'd127);
                checkOutput("pin_lim_done0",  64'(done), 64'd0);
            end
            if (i == 127) checkOutput("pin_lim_done1", 64'(done), 64'd1);
        end
        checkOutput("pin_end_count", 64'(cycleCount), 64'd127);
        checkOutput("pin_end_done",  64'(done), 64'd1);
        checkOutput("pin_end_level", 64'(level), 64'd0);
        for (int i = 0; i < 5; i++) applyStimulus(0, STATE_W'(i + 10), 32'd0, 1, 64'h300, 0);
        checkOutput("pin_nopush_level", 64'(level), 64'd0);
        checkOutput("pin_noexc",        64'(excValid), 64'd0);

        checkEn = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
